axis_cmd_gen_mm2s: RTL

AXIS_CMD_GEN_MM2S -- requirements
Module: axis_cmd_gen_mm2s

---
 rtl/axis_cmd_gen_mm2s_pkg.sv | 52 +++++
 rtl/axis_cmd_gen_mm2s_if.sv | 21 ++
 rtl/axis_cmd_gen_mm2s.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axis_cmd_gen_mm2s_pkg.sv
// Shared types and field layout for the MM2S command generator.
// Datamover command/status bit positions live here.
package axis_cmd_gen_mm2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int PACKET_SIZE_DEF = 4096;

  localparam int CMD_W    = 72;
  localparam int BTT_LSB  = 0;
  localparam int BTT_W    = 23;
  localparam int TYPE_BIT = 23;
  localparam int EOF_BIT  = 30;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_W   = 32;
  localparam int TAG_LSB  = 64;
  localparam int TAG_W    = 4;

  localparam int STS_W       = 8;
  localparam int STS_OK_BIT  = 7;
  localparam int STS_ERR_LSB = 4;
  localparam int STS_ERR_W   = 3;

  function automatic logic [CMD_W-1:0] make_cmd(
    input logic [ADDR_W-1:0] addr,
    input logic [BTT_W-1:0]  btt,
    input logic              eof,
    input logic [TAG_W-1:0]  tag
  );
    logic [CMD_W-1:0] c;
    c = '0;
    c[BTT_LSB +: BTT_W]   = btt;
    c[TYPE_BIT]           = 1'b1;
    c[EOF_BIT]            = eof;
    c[ADDR_LSB +: ADDR_W] = addr;
    c[TAG_LSB +: TAG_W]   = tag;
    return c;
  endfunction

  function automatic logic sts_is_bad(
    input logic                 okay,
    input logic [STS_ERR_W-1:0] err
  );
    return !okay || (err != '0);
  endfunction

endpackage

// File: rtl/axis_cmd_gen_mm2s_if.sv
// Minimal AXI-Stream channel bundle.
// Width is set per instance (command vs status).
interface axis_cmd_gen_mm2s_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_cmd_gen_mm2s.sv
// MM2S datamover command generator: walks a memory region
// in PACKET_SIZE chunks, optionally looping, with a credit limit.
module axis_cmd_gen_mm2s
  import axis_cmd_gen_mm2s_pkg::*;
#(
  parameter int PACKET_SIZE     = PACKET_SIZE_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       axilite_clk,
  input  logic                       axilite_rst,
  input  logic                       read_start,
  input  logic                       read_reset,
  input  logic                       loop_en,
  input  logic [31:0]                base_addr,
  input  logic [31:0]                play_size,
  axis_cmd_gen_mm2s_if.master        m_axis,
  axis_cmd_gen_mm2s_if.slave         s_axis_sts,
  output logic                       busy,
  output logic                       play_done,
  output logic                       sts_error,
  output logic [15:0]                cmd_count,
  output logic [7:0]                 loop_count
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [31:0]   PKT     = 32'(PACKET_SIZE);

  state_t        state, state_n;
  logic [31:0]   base_r, size_r;
  logic          loop_r;
  logic [31:0]   addr, addr_n;
  logic [31:0]   rem, rem_n;
  logic [31:0]   btt;
  logic [BTT_W-1:0] btt_n;
  logic [OW-1:0] outst, outst_n;
  logic [15:0]   cmd_n;
  logic [7:0]    loop_n;
  logic          cmd_hs, sts_hs, run, start_ok;
  logic          inc, dec, bad, hold, err_n;

  assign s_axis_sts.tready = 1'b1;

  // Next-state and datapath updates for the coming edge.
  always_comb begin
    cmd_hs   = m_axis.tvalid & m_axis.tready;
    sts_hs   = s_axis_sts.tvalid;
    run      = (state == ISSUE) || (state == DRAIN);
    start_ok = read_start && (play_size != '0) &&
               ((state == IDLE) || (state == DONE));
    btt      = (rem > PKT) ? PKT : rem;
    inc      = cmd_hs;
    dec      = run && sts_hs && ((outst != '0) || inc);
    outst_n  = outst + OW'(inc) - OW'(dec);
    bad      = sts_is_bad(s_axis_sts.tdata[STS_OK_BIT],
                 s_axis_sts.tdata[STS_ERR_LSB +: STS_ERR_W]);
    hold     = m_axis.tvalid && !m_axis.tready;
    state_n  = state;
    addr_n   = addr;
    rem_n    = rem;
    cmd_n    = cmd_count;
    loop_n   = loop_count;
    err_n    = sts_error | (run && sts_hs && bad);
    unique case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_n = ISSUE;
          addr_n  = base_addr;
          rem_n   = play_size;
          cmd_n   = '0;
          loop_n  = '0;
          err_n   = 1'b0;
        end
      end
      ISSUE: begin
        if (cmd_hs) begin
          addr_n = addr + btt;
          rem_n  = rem - btt;
          cmd_n  = cmd_count + 16'd1;
          if (rem == btt) begin
            if (loop_r) begin
              addr_n = base_r;
              rem_n  = size_r;
              loop_n = (loop_count == 8'hFF) ?
                       loop_count : loop_count + 8'd1;
            end else begin
              state_n = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (outst == '0) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    btt_n = (rem_n > PKT) ? PKT[BTT_W-1:0] : rem_n[BTT_W-1:0];
  end

  // State, counters and registered command/status outputs.
  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      state         <= IDLE;
      base_r        <= '0;
      size_r        <= '0;
      loop_r        <= 1'b0;
      addr          <= '0;
      rem           <= '0;
      outst         <= '0;
      cmd_count     <= '0;
      loop_count    <= '0;
      busy          <= 1'b0;
      play_done     <= 1'b0;
      sts_error     <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
    end else if (read_reset) begin
      state         <= IDLE;
      outst         <= '0;
      cmd_count     <= '0;
      loop_count    <= '0;
      busy          <= 1'b0;
      play_done     <= 1'b0;
      sts_error     <= 1'b0;
      m_axis.tvalid <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      rem        <= rem_n;
      outst      <= outst_n;
      cmd_count  <= cmd_n;
      loop_count <= loop_n;
      sts_error  <= err_n;
      busy       <= (state_n == ISSUE) || (state_n == DRAIN);
      play_done  <= (state_n == DONE);
      if (start_ok) begin
        base_r <= base_addr;
        size_r <= play_size;
        loop_r <= loop_en;
      end
      if (!hold) begin
        m_axis.tvalid <= (state_n == ISSUE) && (outst_n < OUT_MAX);
        m_axis.tdata  <= make_cmd(addr_n, btt_n, rem_n <= PKT,
                                  cmd_n[TAG_W-1:0]);
      end
    end
  end

endmodule
